// File: rtl/oclib_uart_pkg.sv
// Shared UART library constants and helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package oclib_uart_pkg;

  // Default idle-lock release limit for the TX arbiter, in core cycles.
  localparam int TxArbTimeoutDefault = 1024;

  // Width of a counter that must hold the value 'limit' (never below 1 bit).
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/oclib_rr_pick.sv
// Round-robin picker: first set request strictly after last_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req_i request vector, last_i previous winner, idx_o winner, any_o any request set.
module oclib_rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic         hi_any;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;

  // Scan downward so the last hit seen is the lowest index: hi_idx is the
  // lowest requester above last_i, lo_idx the lowest overall (wrap case).
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = W'(i);
        if (i > int'(last_i)) begin
          hi_idx = W'(i);
          hi_any = 1'b1;
        end
      end
    end
    idx_o = hi_any ? hi_idx : lo_idx;
    any_o = |req_i;
  end

endmodule

// File: rtl/oc_uart_tx_arbiter.sv
// Message-atomic round-robin arbiter merging NumReq byte streams onto one UART TX channel.
// Latency: bytes pass combinationally while locked; one idle bubble between messages.
// Backpressure: txReady routed straight to the lock holder's reqReady; all others stall.
// Ports: clock/reset (async, active-high); reqValid/reqData/reqLast/reqReady per requester;
//        txValid/txData/txReady toward UART; grantActive/grantIdx lock status;
//        timeoutPulse one cycle when an idle lock is force-released.
module oc_uart_tx_arbiter
  import oclib_uart_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = TxArbTimeoutDefault
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NumReq-1:0]         reqValid,
  input  logic [NumReq*8-1:0]       reqData,
  input  logic [NumReq-1:0]         reqLast,
  output logic [NumReq-1:0]         reqReady,
  output logic                      txValid,
  output logic [7:0]                txData,
  input  logic                      txReady,
  output logic                      grantActive,
  output logic [$clog2(NumReq)-1:0] grantIdx,
  output logic                      timeoutPulse
);

  localparam int              IdxW   = $clog2(NumReq);
  localparam int              CntW   = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam bit              TmoEn  = (TimeoutCycles != 0);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic            g_valid, g_last, xfer;
  logic [7:0]      g_data;

  oclib_rr_pick #(.N(NumReq), .W(IdxW)) u_pick (
    .req_i  (reqValid),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Select the lock holder's request lane.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_q == IdxW'(i)) begin
        g_valid = reqValid[i];
        g_last  = reqLast[i];
        g_data  = reqData[i*8 +: 8];
      end
    end
  end

  assign xfer    = (state_q == StLocked) && g_valid && txReady;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    txValid      = 1'b0;
    txData       = '0;
    reqReady     = '0;
    timeoutPulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d = StLocked;
          grant_d = pick_idx;
        end
      end
      StLocked: begin
        // txValid comes only from the holder's valid, never from txReady.
        txValid = g_valid;
        txData  = g_data;
        for (int i = 0; i < NumReq; i++) begin
          reqReady[i] = (grant_q == IdxW'(i)) && txReady;
        end
        if (xfer) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (!g_valid) begin
          // Idle cycles only; a transferring cycle never reaches here, so a
          // last-byte transfer always takes precedence over the timeout.
          cnt_d = cnt_inc;
          if (TmoEn && (cnt_inc == CntMax)) begin
            state_d      = StIdle;
            last_d       = grant_q;
            cnt_d        = '0;
            timeoutPulse = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    grantActive = (state_q == StLocked);
    grantIdx    = (state_q == StLocked) ? grant_q : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NumReq - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_oc_uart_tx_arbiter.sv
// Self-checking bench: message-level round-robin reference model for a 2-requester
// instance, directed timeout and 4-way rotation checks on a second instance.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_oc_uart_tx_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Instance A: 2 requesters, default timeout
  logic        rst_a;
  logic [1:0]  av, al, a_rdy;
  logic [15:0] ad;
  logic        a_txv, a_txr, a_ga, a_tp;
  logic [7:0]  a_txd;
  logic [0:0]  a_gi;

  // Instance B: 4 requesters, timeout 16
  logic        rst_b;
  logic [3:0]  bv, bl, b_rdy;
  logic [31:0] bd;
  logic        b_txv, b_txr, b_ga, b_tp;
  logic [7:0]  b_txd;
  logic [1:0]  b_gi;

  oc_uart_tx_arbiter #(.NumReq(2)) u_a (
    .clock(clock), .reset(rst_a), .reqValid(av), .reqData(ad), .reqLast(al),
    .reqReady(a_rdy), .txValid(a_txv), .txData(a_txd), .txReady(a_txr),
    .grantActive(a_ga), .grantIdx(a_gi), .timeoutPulse(a_tp)
  );

  oc_uart_tx_arbiter #(.NumReq(4), .TimeoutCycles(16)) u_b (
    .clock(clock), .reset(rst_b), .reqValid(bv), .reqData(bd), .reqLast(bl),
    .reqReady(b_rdy), .txValid(b_txv), .txData(b_txd), .txReady(b_txr),
    .grantActive(b_ga), .grantIdx(b_gi), .timeoutPulse(b_tp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Per-requester pending bytes for instance A, and the expected TX stream.
  logic [7:0] q_dat[2][$];
  bit         q_last[2][$];
  int         q_gap[2][$];
  logic [7:0] e_dat[$];
  int         e_src[$];
  bit         e_last[$];
  int         m_last;

  task automatic add_byte(input int r, input logic [7:0] d, input bit lst, input int gap);
    q_dat[r].push_back(d);
    q_last[r].push_back(lst);
    q_gap[r].push_back(gap);
  endtask

  // Whole messages are granted round-robin among requesters that still have one.
  task automatic build_expected();
    int pos[2];
    int sel;
    int c;
    bit more;
    bit lst;
    pos[0] = 0;
    pos[1] = 0;
    more = 1'b1;
    while (more) begin
      more = 1'b0;
      sel = 0;
      for (int k = 1; k <= 2; k++) begin
        c = (m_last + k) % 2;
        if (!more && pos[c] < q_dat[c].size()) begin
          more = 1'b1;
          sel = c;
        end
      end
      if (more) begin
        lst = 1'b0;
        while (!lst) begin
          lst = q_last[sel][pos[sel]];
          e_dat.push_back(q_dat[sel][pos[sel]]);
          e_src.push_back(sel);
          e_last.push_back(lst);
          pos[sel]++;
        end
        m_last = sel;
      end
    end
  endtask

  // mode 0: txReady=1, 1: toggling from 1, 2: random
  task automatic run_engine(input int mode, input int budget);
    int pend[2];
    int cyc;
    int bub;
    bit done;
    bit tgl;
    logic [1:0] allowed;
    pend[0] = 0;
    pend[1] = 0;
    bub = 0;
    tgl = 1'b1;
    cyc = 0;
    done = 1'b0;
    build_expected();
    while (!done && cyc < budget) begin
      @(posedge clock); #1;
      for (int r = 0; r < 2; r++) begin
        if (pend[r] > 0) begin
          av[r] = 1'b0;
          ad[r*8 +: 8] = 8'($urandom);
          al[r] = 1'($urandom);
          pend[r]--;
        end else if (q_dat[r].size() > 0) begin
          av[r] = 1'b1;
          ad[r*8 +: 8] = q_dat[r][0];
          al[r] = q_last[r][0];
        end else begin
          av[r] = 1'b0;
          ad[r*8 +: 8] = 8'($urandom);
          al[r] = 1'($urandom);
        end
      end
      if (mode == 0) a_txr = 1'b1;
      else if (mode == 1) begin a_txr = tgl; tgl = ~tgl; end
      else a_txr = ($urandom_range(0, 9) < 7);
      @(negedge clock);
      cyc++;
      if (bub == 1) begin
        chk("bubble_idle", a_ga, 0);
        bub = (q_dat[0].size() + q_dat[1].size() > 0) ? 2 : 0;
      end else if (bub == 2) begin
        chk("bubble_relock", a_ga, 1);
        bub = 0;
      end
      allowed = (e_dat.size() > 0) ? (2'b01 << e_src[0]) : 2'b00;
      chk("rdy_owner_only", a_rdy & ~allowed, 0);
      if (mode == 1 && a_ga) chk("rdy_mirror", a_rdy[1], a_txr);
      if (a_txv && a_txr) begin
        if (e_dat.size() == 0) chk("extra_byte", a_txv, 0);
        else begin
          chk("tx_data", a_txd, e_dat[0]);
          chk("grant_idx", a_gi, e_src[0]);
          if (e_last[0]) bub = 1;
          void'(e_dat.pop_front());
          void'(e_src.pop_front());
          void'(e_last.pop_front());
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (av[r] && a_rdy[r] && q_dat[r].size() > 0) begin
          pend[r] = q_gap[r][0];
          void'(q_dat[r].pop_front());
          void'(q_last[r].pop_front());
          void'(q_gap[r].pop_front());
        end
      end
      done = (e_dat.size() == 0) && (q_dat[0].size() == 0) && (q_dat[1].size() == 0);
    end
    chk("engine_complete", done, 1);
    @(posedge clock); #1;
    av = '0;
    al = '0;
    a_txr = 1'b1;
  endtask

  initial begin
    int idle;
    int n;
    int cyc;
    int prev;
    int len;
    int nm;

    rst_a = 1'b1; av = 2'b11; al = 2'b00; ad = 16'h1234; a_txr = 1'b1;
    rst_b = 1'b1; bv = '0; bl = '0; bd = '0; b_txr = 1'b1;
    m_last = 1;

    // Reset state with requests pending
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_txvalid", a_txv, 0);
    chk("rst_reqready", a_rdy, 0);
    chk("rst_grantactive", a_ga, 0);
    chk("rst_grantidx", a_gi, 0);
    chk("rst_timeout", a_tp, 0);
    chk("rst_b_grantactive", b_ga, 0);
    av = 2'b00;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // "OC>" from req0 and "ERR" from req1: req0 first after reset
    add_byte(0, 8'h4F, 0, 0); add_byte(0, 8'h43, 0, 0); add_byte(0, 8'h3E, 1, 0);
    add_byte(1, 8'h45, 0, 0); add_byte(1, 8'h52, 0, 0); add_byte(1, 8'h52, 1, 0);
    run_engine(0, 100);

    // req1 alone under toggling txReady
    add_byte(1, 8'h41, 0, 0); add_byte(1, 8'h42, 1, 0);
    run_engine(1, 100);

    // req0 stalls 500 cycles mid-message while req1 waits
    add_byte(0, 8'h30, 0, 500); add_byte(0, 8'h31, 0, 0); add_byte(0, 8'h32, 1, 0);
    add_byte(1, 8'h40, 1, 0);
    run_engine(2, 800);

    // Random messages, random mid-message gaps, random txReady
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 2; r++) begin
        nm = $urandom_range(2, 4);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            add_byte(r, 8'($urandom), (b == len - 1),
                     (b == len - 1) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0));
          end
        end
      end
      run_engine(2, 2000);
    end

    // Asynchronous reset mid-message
    @(posedge clock); #1;
    av = 2'b01; ad[7:0] = 8'hA0; al = 2'b00; a_txr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (a_txv) break;
    end
    chk("rst_mid_locked", a_txv, 1);
    #2 rst_a = 1'b1;
    #1;
    chk("rst_mid_txvalid", a_txv, 0);
    chk("rst_mid_grantactive", a_ga, 0);
    chk("rst_mid_reqready", a_rdy, 0);
    chk("rst_mid_grantidx", a_gi, 0);
    @(posedge clock);
    @(negedge clock);
    rst_a = 1'b0;
    m_last = 1;
    add_byte(0, 8'hB1, 1, 0);
    add_byte(1, 8'hC2, 1, 0);
    run_engine(0, 50);

    // Instance B: timeout after 16 idle cycles, grant passes to req1
    @(posedge clock); #1;
    bv = 4'b0011; bd[7:0] = 8'h55; bd[15:8] = 8'h66; bl = 4'b0010; b_txr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (b_txv && b_txr) break;
    end
    chk("to_first_grant", b_gi, 0);
    chk("to_first_data", b_txd, 8'h55);
    @(posedge clock); #1;
    bv[0] = 1'b0;
    idle = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!(b_ga && b_gi == 2'd0 && !b_txv)) break;
      idle++;
      chk("to_pulse", b_tp, (idle == 16));
      chk("to_req1_stall", b_rdy[1], 0);
      if (idle == 16) break;
    end
    chk("to_idle_count", idle, 16);
    @(negedge clock);
    chk("to_release", b_ga, 0);
    chk("to_pulse_width", b_tp, 0);
    @(negedge clock);
    chk("to_next_active", b_ga, 1);
    chk("to_next_grant", b_gi, 1);
    chk("to_next_data", b_txd, 8'h66);
    @(posedge clock); #1;
    bv = '0;

    // Instance B: 4 requesters, continuous 1-byte messages
    rst_b = 1'b1;
    @(negedge clock);
    rst_b = 1'b0;
    bv = 4'hF; bl = 4'hF; bd = 32'h13121110; b_txr = 1'b1;
    n = 0; cyc = 0; prev = 0;
    while (n < 8 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (b_txv && b_txr) begin
        chk("rr_grant", b_gi, n % 4);
        chk("rr_data", b_txd, 8'h10 + n % 4);
        if (n > 0) chk("rr_spacing", cyc - prev, 2);
        prev = cyc;
        n++;
      end
    end
    chk("rr_count", n, 8);
    rst_b = 1'b1;
    bv = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
